axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// AXI slave that serves INCR bursts of 8-byte beats out of a single-port SRAM.
// One transaction at a time, with round-robin arbitration between the write and read channels.
module axi_sram_slave #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ID_W-1:0]       awid_i,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic [7:0]            awlen_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic                  wlast_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [ID_W-1:0]       bid_o,
  output logic [1:0]            bresp_o,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ID_W-1:0]       arid_i,
  input  logic [ADDR_W-1:0]     araddr_i,
  input  logic [7:0]            arlen_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [ID_W-1:0]       rid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  ram_en_o,
  output logic [DATA_W/8-1:0]   ram_we_o,
  output logic [DEPTH_LOG2-1:0] ram_addr_o,
  output logic [DATA_W-1:0]     ram_wdata_o,
  input  logic [DATA_W-1:0]     ram_rdata_i
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrData = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdAddr = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;

  localparam logic [DEPTH_LOG2-1:0] IdxOne = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic                  last_rd_q, last_rd_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  decerr_q, decerr_d;
  logic                  wl_err_q, wl_err_d;

  logic grant_w, grant_r, last_beat;
  logic unused_addr_lsbs;

  // Byte offset within a beat is irrelevant for 8-byte beats.
  assign unused_addr_lsbs = ^{awaddr_i[2:0], araddr_i[2:0]};

  // On a tie the side not granted last wins; a sole requester always wins.
  assign grant_w   = awvalid_i & (~arvalid_i | last_rd_q);
  assign grant_r   = arvalid_i & (~awvalid_i | ~last_rd_q);
  assign last_beat = (beat_q == len_q);

  assign bid_o      = id_q;
  assign rid_o      = id_q;
  assign ram_addr_o = idx_q;

  always_comb begin
    state_d     = state_q;
    last_rd_d   = last_rd_q;
    id_d        = id_q;
    len_d       = len_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    decerr_d    = decerr_q;
    wl_err_d    = wl_err_q;
    awready_o   = 1'b0;
    arready_o   = 1'b0;
    wready_o    = 1'b0;
    bvalid_o    = 1'b0;
    bresp_o     = 2'b00;
    rvalid_o    = 1'b0;
    rdata_o     = '0;
    rresp_o     = 2'b00;
    rlast_o     = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_wdata_o = '0;
    case (state_q)
      StIdle: begin
        awready_o = rst_n & grant_w;
        arready_o = rst_n & grant_r;
        if (grant_w) begin
          id_d      = awid_i;
          len_d     = awlen_i;
          idx_d     = awaddr_i[DEPTH_LOG2+2:3];
          decerr_d  = |awaddr_i[ADDR_W-1:DEPTH_LOG2+3];
          beat_d    = 8'd0;
          wl_err_d  = 1'b0;
          last_rd_d = 1'b0;
          state_d   = StWrData;
        end else if (grant_r) begin
          id_d      = arid_i;
          len_d     = arlen_i;
          idx_d     = araddr_i[DEPTH_LOG2+2:3];
          decerr_d  = |araddr_i[ADDR_W-1:DEPTH_LOG2+3];
          beat_d    = 8'd0;
          wl_err_d  = 1'b0;
          last_rd_d = 1'b1;
          state_d   = StRdAddr;
        end
      end
      StWrData: begin
        wready_o    = 1'b1;
        ram_wdata_o = wdata_i;
        if (wvalid_i) begin
          ram_en_o = ~decerr_q;
          ram_we_o = decerr_q ? '0 : wstrb_i;
          idx_d    = idx_q + IdxOne;
          beat_d   = beat_q + 8'd1;
          // wlast must appear exactly on the final beat.
          if (last_beat) begin
            if (!wlast_i) wl_err_d = 1'b1;
            state_d = StWrResp;
          end else if (wlast_i) begin
            wl_err_d = 1'b1;
          end
        end
      end
      StWrResp: begin
        bvalid_o = 1'b1;
        bresp_o  = decerr_q ? 2'b11 : (wl_err_q ? 2'b10 : 2'b00);
        if (bready_i) state_d = StIdle;
      end
      StRdAddr: begin
        ram_en_o = ~decerr_q;
        state_d  = StRdData;
      end
      StRdData: begin
        rvalid_o = 1'b1;
        rlast_o  = last_beat;
        rresp_o  = decerr_q ? 2'b11 : 2'b00;
        rdata_o  = decerr_q ? '0 : ram_rdata_i;
        if (rready_i) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + IdxOne;
            beat_d  = beat_q + 8'd1;
            state_d = StRdAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_rd_q <= 1'b1;
      id_q      <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      idx_q     <= '0;
      decerr_q  <= 1'b0;
      wl_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      decerr_q  <= decerr_d;
      wl_err_q  <= wl_err_d;
    end
  end

endmodule
